// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state codes, light encodings and default phase timings
package traffic_pkg;
    typedef enum logic [2:0] {
        NSG_EWR = 3'd0,
        NSY_EWR = 3'd1,
        ALLRED  = 3'd2,
        NSR_EWG = 3'd3,
        NSR_EWY = 3'd4
    } state_t;
    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam int DEF_MIN_GREEN   = 5;
    localparam int DEF_MAX_GREEN   = 10;
    localparam int DEF_YELLOW_TIME = 3;
    localparam int DEF_ALLRED_TIME = 1;
endpackage

// File: rtl/traffic_light_decoder.sv
// traffic_light_decoder: state_i -> ns_light_o/ew_light_o one-hot {red,yellow,green}; illegal codes show red both ways
module traffic_light_decoder
    import traffic_pkg::*;
(
    input  state_t     state_i,
    output logic [2:0] ns_light_o,
    output logic [2:0] ew_light_o
);
    assign ns_light_o = state_i == NSG_EWR ? LIGHT_GREEN :
                        state_i == NSY_EWR ? LIGHT_YELLOW : LIGHT_RED;
    assign ew_light_o = state_i == NSR_EWG ? LIGHT_GREEN :
                        state_i == NSR_EWY ? LIGHT_YELLOW : LIGHT_RED;
endmodule

// File: rtl/traffic_light_controller_sim.sv
// traffic_light_controller_sim: sensor-driven NS/EW Moore controller; ports clk, rst, NS_sensor, EW_sensor -> NS_light, EW_light, clk_count, state, prev_state
module traffic_light_controller_sim
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN   = DEF_MIN_GREEN,
    parameter int MAX_GREEN   = DEF_MAX_GREEN,
    parameter int YELLOW_TIME = DEF_YELLOW_TIME,
    parameter int ALLRED_TIME = DEF_ALLRED_TIME
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       NS_sensor,
    input  logic       EW_sensor,
    output logic [2:0] NS_light,
    output logic [2:0] EW_light,
    output logic [3:0] clk_count,
    output logic [2:0] state,
    output logic [2:0] prev_state
);
    localparam logic [3:0] MIN_C = 4'(MIN_GREEN - 1);
    localparam logic [3:0] MAX_C = 4'(MAX_GREEN - 1);
    localparam logic [3:0] YEL_C = 4'(YELLOW_TIME - 1);
    localparam logic [3:0] AR_C  = 4'(ALLRED_TIME - 1);
    state_t     state_q, state_d, prev_q;
    logic [3:0] cnt_q;
    // a green phase yields only when the other road is waiting: early once the
    // minimum has elapsed and its own road is empty, or at the maximum regardless
    function automatic logic yield(input logic [3:0] c, input logic own, input logic other);
        return other && ((c >= MIN_C && !own) || c >= MAX_C);
    endfunction
    always_comb begin
        state_d = state_q;
        case (state_q)
            NSG_EWR: if (yield(cnt_q, NS_sensor, EW_sensor)) state_d = NSY_EWR;
            NSY_EWR: if (cnt_q == YEL_C) state_d = ALLRED;
            ALLRED:  if (cnt_q == AR_C) state_d = prev_q == NSY_EWR ? NSR_EWG : NSG_EWR;
            NSR_EWG: if (yield(cnt_q, EW_sensor, NS_sensor)) state_d = NSR_EWY;
            NSR_EWY: if (cnt_q == YEL_C) state_d = ALLRED;
            default: state_d = NSG_EWR;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NSG_EWR;
            prev_q  <= NSR_EWY;
            cnt_q   <= '0;
        end else if (state_d != state_q) begin
            prev_q  <= state_q;
            state_q <= state_d;
            cnt_q   <= '0;
        end else begin
            cnt_q   <= cnt_q == 4'd15 ? cnt_q : cnt_q + 4'd1;
        end
    end
    traffic_light_decoder u_dec (
        .state_i    (state_q),
        .ns_light_o (NS_light),
        .ew_light_o (EW_light)
    );
    assign state      = state_q;
    assign prev_state = prev_q;
    assign clk_count  = cnt_q;
endmodule

// File: tb/tb_traffic_light_controller_sim.sv
// tb_traffic_light_controller_sim: scoreboarded random/directed check against a phase-sequence reference model
module tb_traffic_light_controller_sim;
    localparam int MIN_G = 5, MAX_G = 10, YEL = 3, AR = 1;
    logic clk = 0, rst = 1, NS_sensor = 0, EW_sensor = 0;
    logic [2:0] NS_light, EW_light, state, prev_state;
    logic [3:0] clk_count;
    always #5 clk = ~clk;
    traffic_light_controller_sim dut (
        .clk(clk), .rst(rst), .NS_sensor(NS_sensor), .EW_sensor(EW_sensor),
        .NS_light(NS_light), .EW_light(EW_light), .clk_count(clk_count),
        .state(state), .prev_state(prev_state)
    );
    typedef struct packed {
        logic [2:0] st;
        logic [2:0] pv;
        logic [3:0] c;
        logic [2:0] ns;
        logic [2:0] ew;
    } exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_bad = 0;
    // the full cycle as a phase list: NSG, NSY, ALLRED, EWG, EWY, ALLRED
    int codes [6] = '{0, 1, 2, 3, 4, 2};
    logic [2:0] ns_tab [5] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
    logic [2:0] ew_tab [5] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010};
    int m_p = 0, m_t = 0, m_prev = 4;
    task automatic tick(input logic r, input logic ns, input logic ew);
        logic own, other, leave;
        exp_t e;
        @(negedge clk);
        rst = r; NS_sensor = ns; EW_sensor = ew;
        if (r) begin
            m_p = 0; m_t = 0; m_prev = 4;
        end else begin
            own   = m_p == 0 ? ns : ew;
            other = m_p == 0 ? ew : ns;
            if (m_p == 0 || m_p == 3)
                leave = other && ((m_t >= MIN_G - 1 && !own) || m_t >= MAX_G - 1);
            else if (m_p == 1 || m_p == 4)
                leave = m_t == YEL - 1;
            else
                leave = m_t == AR - 1;
            if (leave) begin
                m_prev = codes[m_p];
                m_p = (m_p + 1) % 6;
                m_t = 0;
            end else begin
                m_t = m_t < 15 ? m_t + 1 : 15;
            end
        end
        e.st = 3'(codes[m_p]);
        e.pv = 3'(m_prev);
        e.c  = 4'(m_t);
        e.ns = ns_tab[codes[m_p]];
        e.ew = ew_tab[codes[m_p]];
        sb.push_back(e);
    endtask
    initial begin : monitor
        exp_t e, got;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                got = {state, prev_state, clk_count, NS_light, EW_light};
                n_cmp++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL cycle_check t=%0t: got st=%0d pv=%0d c=%0d ns=%b ew=%b, expected st=%0d pv=%0d c=%0d ns=%b ew=%b",
                             $time, got.st, got.pv, got.c, got.ns, got.ew, e.st, e.pv, e.c, e.ns, e.ew);
                end
            end
        end
    end
    initial begin : stim
        int i;
        repeat (3) tick(1, 0, 0);
        repeat (30) tick(0, 0, 0);
        repeat (56) tick(0, 1, 1);
        tick(1, 0, 0);
        repeat (2) tick(0, 1, 0);
        repeat (14) tick(0, 0, 1);
        tick(1, 0, 0);
        repeat (16) tick(0, 0, 0);
        repeat (20) tick(0, 0, 1);
        repeat (15) tick(0, 1, 1);
        repeat (20) tick(0, 0, 1);
        tick(0, 1, 1);
        repeat (15) tick(0, 1, 0);
        tick(1, 0, 0);
        for (i = 0; i < 200 && !(m_p == 4 && m_t == 1); i++) tick(0, 1, 1);
        n_cmp++;
        if (!(m_p == 4 && m_t == 1)) begin
            n_bad++;
            $display("FAIL reach_ewy: model phase=%0d count=%0d, required phase=4 count=1", m_p, m_t);
        end
        tick(1, 1, 1);
        repeat (5) tick(0, 0, 0);
        repeat (3000) tick(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/traffic_light_controller_sim.md
Name: traffic_light_controller_sim

Overview:
Two-way intersection controller for North-South (NS) and East-West (EW) traffic, driven by vehicle-presence sensors. Moore FSM. One clock cycle stands for one "second" tick. It exposes its internal state, previous state and phase counter as debug outputs for simulation visibility. It is a standalone top-level block with no sub-clock divider; a board variant adds its own tick enable externally.

Parameters:
MIN_GREEN, 5, minimum green duration in ticks
MAX_GREEN, 10, green duration in ticks when both directions demand service
YELLOW_TIME, 3, yellow duration in ticks
ALLRED_TIME, 1, all-red clearance duration in ticks

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  reset, synchronous, active-high
NS_sensor  in  1  1 = vehicle waiting or present on NS
EW_sensor  in  1  1 = vehicle waiting or present on EW
NS_light  out  3  {red,yellow,green} one-hot: 100 red, 010 yellow, 001 green
EW_light  out  3  same encoding as NS_light
clk_count  out  4  ticks spent in current state, starting at 0
state  out  3  current FSM state code
prev_state  out  3  last state left before the current one

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- State codes: NSG_EWR=0, NSY_EWR=1, ALLRED=2, NSR_EWG=3, NSR_EWY=4. Codes 5-7 are illegal and go to NSG_EWR on the next edge with clk_count=0.
- Reset values: state=NSG_EWR, prev_state=NSR_EWY, clk_count=0, NS_light=001, EW_light=100.
- Lights are decoded combinationally from state only:
  - NSG_EWR: NS=001, EW=100
  - NSY_EWR: NS=010, EW=100
  - ALLRED: NS=100, EW=100
  - NSR_EWG: NS=100, EW=001
  - NSR_EWY: NS=100, EW=010
- clk_count:
  - Goes to 0 on the edge that changes state.
  - Otherwise increments by 1 each edge, saturating at 15.
- prev_state loads the old state on every state change. It holds otherwise.
- Sensors are sampled at the clock edge. Let c = clk_count before the edge.
- NSG_EWR, with own=NS_sensor and other=EW_sensor:
  - Go to NSY_EWR if (c>=MIN_GREEN-1 && other && !own) or (c>=MAX_GREEN-1 && other).
  - Otherwise stay. With no EW demand it rests on green indefinitely, and clk_count saturates at 15.
  - An EW arrival before the 5-tick mark waits until c=4. An arrival after the mark causes a transition on the next edge.
- NSR_EWG: symmetric to NSG_EWR, with own=EW_sensor, other=NS_sensor. Exit goes to NSR_EWY.
- NSY_EWR and NSR_EWY: go to ALLRED when c==YELLOW_TIME-1. Sensors are ignored.
- ALLRED: when c==ALLRED_TIME-1, go to NSR_EWG if prev_state==NSY_EWR, else go to NSG_EWR.
- Constant demand on both sensors gives a 28-tick cycle: NSG 10, NSY 3, ALLRED 1, EWG 10, EWY 3, ALLRED 1.
- Reset asserted mid-phase returns to reset values on that edge, whatever state or count is current.
- Sensor changes during yellow or all-red have no effect.

Decomposition:
- Shared package traffic_pkg holds:
  - state enum/localparams (NSG_EWR..NSR_EWY)
  - light codes LIGHT_RED=3'b100, LIGHT_YELLOW=3'b010, LIGHT_GREEN=3'b001
  - default timing constants
- One optional sub-module, traffic_light_decoder: combinational state -> NS_light/EW_light.
- FSM, counter and prev_state register stay in the top module.

Test Plan:
- Reset with sensors 0 for 3 edges -> state=0, prev_state=4, clk_count=0, NS=001, EW=100. Keep sensors 0 for 30 edges -> stays NSG_EWR, clk_count saturates at 15.
- Both sensors held 1 for 56 edges -> sequence NSG(count 0..9), NSY(0..2), ALLRED(0), NSR_EWG(0..9), NSR_EWY(0..2), ALLRED, repeating; prev_state=1 during the first ALLRED, 4 during the second.
- After reset, NS=1, EW=0. EW rises when clk_count=2 -> NSY_EWR entered on the edge after count 4, i.e. 5 ticks of green in total.
- After reset, rest on NS green until clk_count=15. Then EW=1, NS=0 -> NSY_EWR on the next edge, then ALLRED, then NSR_EWG with EW=001.
- In NSR_EWG with EW=1 and NS=0 -> rests on EW green. NS rises with EW still 1 -> exits at c=9. NS rises with EW dropped -> exits at max(c,4).
- Assert rst during NSR_EWY at clk_count=1 -> next edge gives state=0, clk_count=0, prev_state=4, NS=001.
